// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
//
// A muldiv strobe from the decoder is accepted in IDLE. The unit then runs
// WIDTH single-bit iterations (radix-2 shift-add for multiplies, restoring
// shift-subtract for divides) on operand magnitudes. It applies the sign
// fix-up while entering DONE and presents a registered result with a
// one-cycle done pulse. Latency is fixed at WIDTH+1 cycles for every op.
//
// Ports:
//   clock   in   1      system clock, all state on rising edge
//   reset   in   1      synchronous active-high reset
//   start   in   1      muldiv strobe, sampled only in IDLE
//   funct3  in   3      RV32M operation select
//   opa     in   WIDTH  rs1 value
//   opb     in   WIDTH  rs2 value
//   busy    out  1      high in RUN and DONE (pipeline stall)
//   done    out  1      one-cycle pulse, result valid
//   result  out  WIDTH  registered result, held until next DONE
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic               a_neg_q;
  logic               b_neg_q;
  logic               b_zero_q;
  logic [WIDTH-1:0]   b_mag_q;
  // Shared datapath register: product {hi,lo} for multiplies,
  // {remainder, quotient/dividend} for divides.
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  logic               a_signed_s;
  logic               b_signed_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH+1:0]   div_trial_s;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   result_d;

  // Operand decode at accept: signedness per funct3, sign flags, magnitudes.
  always_comb begin
    a_signed_s = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_s = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                 (funct3 == 3'b110);
    a_neg_s    = a_signed_s & opa[WIDTH-1];
    b_neg_s    = b_signed_s & opb[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = {WIDTH{1'b0}} - opa;
    end else begin
      a_mag_s = opa;
    end
    if (b_neg_s) begin
      b_mag_s = {WIDTH{1'b0}} - opb;
    end else begin
      b_mag_s = opb;
    end
  end

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide).
  always_comb begin
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_mag_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    // Two extra bits so the borrow of {rem, next dividend bit} - divisor
    // shows up in the top bit.
    div_trial_s = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} -
                  {2'b00, b_mag_q};
    if (op_q[2]) begin
      if (!div_trial_s[WIDTH+1]) begin
        acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result select, applied to the final iteration's value.
  // Signed overflow falls out naturally: |quotient| = 2^(WIDTH-1) negates to itself.
  always_comb begin
    if (a_neg_q ^ b_neg_q) begin
      prod_s = {(2*WIDTH){1'b0}} - acc_d;
    end else begin
      prod_s = acc_d;
    end
    if (b_zero_q) begin
      quo_s = {WIDTH{1'b1}};
    end else if (a_neg_q ^ b_neg_q) begin
      quo_s = {WIDTH{1'b0}} - acc_d[WIDTH-1:0];
    end else begin
      quo_s = acc_d[WIDTH-1:0];
    end
    // Divide by zero leaves |opa| here, so this also restores opa itself.
    if (a_neg_q) begin
      rem_s = {WIDTH{1'b0}} - acc_d[2*WIDTH-1:WIDTH];
    end else begin
      rem_s = acc_d[2*WIDTH-1:WIDTH];
    end
    case (op_q)
      3'b000:                 result_d = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result_d = quo_s;
      3'b110, 3'b111:         result_d = rem_s;
      default:                result_d = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM with registered busy/done/result and operand latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 3'b000;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      b_mag_q  <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= {CW{1'b0}};
            op_q     <= funct3;
            a_neg_q  <= a_neg_s;
            b_neg_q  <= b_neg_s;
            b_zero_q <= (opb == {WIDTH{1'b0}});
            b_mag_q  <= b_mag_s;
            acc_q    <= {{WIDTH{1'b0}}, a_mag_s};
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= result_d;
          end else begin
            done_q <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH = 32).
// Inputs are driven on the falling edge and outputs are sampled there too,
// away from the rising active edge.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests;
  int n_fail;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op with start high for a single cycle. The op is accepted at the
  // end of cycle T. The task checks busy at T+1, done first seen at T+33, the
  // result, and the return to idle with the result held.
  task automatic do_op(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int k;
    @(negedge clock);
    start = 1'b1; funct3 = f3; opa = a; opb = b;
    @(negedge clock);
    start = 1'b0; opa = $urandom; opb = $urandom; funct3 = 3'($urandom);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    k = 1;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check({tag, ".lat"}, 64'(k), 64'd33);
    check({tag, ".res"}, 64'(result), 64'(exp));
    @(negedge clock);
    check({tag, ".idle"}, {62'd0, busy, done}, 64'd0);
    check({tag, ".hold"}, 64'(result), 64'(exp));
  endtask

  initial begin
    int k;
    int pulses;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; start = 1'b0; funct3 = 3'b000; opa = 32'd0; opb = 32'd0;
    repeat (2) @(negedge clock);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.res", 64'(result), 64'd0);
    reset = 1'b0;

    do_op("mul_7_m3",   3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh_min",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
    do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    do_op("divu_2",     3'b101, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC);
    do_op("remu_2",     3'b111, 32'hFFFF_FFF9,  32'd2,         32'd1);
    do_op("div_by0",    3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF);
    do_op("remu_by0",   3'b111, 32'd5,          32'd0,         32'd5);
    do_op("rem_m5_by0", 3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);
    do_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    do_op("div_100_m7", 3'b100, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2);
    do_op("rem_m100_7", 3'b110, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE);

    // Back-to-back: start held high through RUN and DONE must be ignored.
    @(negedge clock);
    start = 1'b1; funct3 = 3'b000; opa = 32'd3; opb = 32'd4;
    @(negedge clock);
    opa = 32'd9; opb = 32'd9;
    k = 1;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("b2b.lat1", 64'(k), 64'd33);
    check("b2b.res1", 64'(result), 64'd12);
    @(negedge clock);
    check("b2b.idle", 64'(busy), 64'd0);
    @(negedge clock);
    start = 1'b0;
    check("b2b.busy2", 64'(busy), 64'd1);
    k = 1;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("b2b.lat2", 64'(k), 64'd33);
    check("b2b.res2", 64'(result), 64'd81);
    @(negedge clock);

    // Reset mid-RUN: no done pulse, outputs cleared, then a fresh op runs.
    @(negedge clock);
    start = 1'b1; funct3 = 3'b101; opa = 32'd100; opb = 32'd7;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) pulses++;
      if (i == 9) check("rst_mid.busy", 64'(busy), 64'd1);
      if (i == 10) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    if (done) pulses++;
    check("rst_mid.busy0", 64'(busy), 64'd0);
    check("rst_mid.res0", 64'(result), 64'd0);
    check("rst_mid.nopulse", 64'(pulses), 64'd0);
    do_op("mul_2_2", 3'b000, 32'd2, 32'd2, 32'd4);

    // Reset wins over start on the same edge.
    @(negedge clock);
    reset = 1'b1; start = 1'b1; funct3 = 3'b000; opa = 32'd5; opb = 32'd5;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("rst_prio.busy", 64'(busy), 64'd0);
    check("rst_prio.res", 64'(result), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
